ps2_ascii_fifo: RTL
===================

# ps2_ascii_fifo

Downstream consumer of the `ps2keyboard` receiver: takes raw PS/2 set-2 scancode bytes and their one-cycle strobe. It tracks the E0/F0 prefix state and the modifier state, and translates make codes to 8-bit character codes. Results are buffered in a small FIFO behind a valid/ready interface read by the CPU/terminal logic that writes video memory.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `clock`  in  1  system clock; same domain as `ps2keyboard` output.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_data`  in  8  received scancode byte; valid only when `ps2_hit`=1.
- `ps2_hit`  in  1  one-cycle strobe per received byte.
- `out_data`  out  8  character code at FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer pops head when `out_valid`&&`out_ready`.
- `mod_shift`  out  1  either Shift held.
- `mod_ctrl`  out  1  either Ctrl held.
- `mod_caps`  out  1  Caps Lock toggle state.
- `overflow`  out  1  one-cycle pulse when a character is dropped on full FIFO.

## Operation
- Prefix FSM, advanced only on `ps2_hit`:
  - IDLE: E0 -> EXT; F0 -> BRK; other -> make(code, ext=0), stay IDLE.
  - EXT: F0 -> EXTBRK; other -> make(code, ext=1) -> IDLE.
  - BRK: any -> break(code, ext=0) -> IDLE.
  - EXTBRK: any -> break(code, ext=1) -> IDLE.
- Bytes AA, FA, EE, FE, 00, FF in IDLE are ignored; the FSM stays IDLE.
- Modifiers:
  - Shift is 12 or 59; Ctrl is 14 or E0 14.
  - Make sets the modifier; break clears it.
  - Left and right keys are tracked separately and ORed.
- Caps: make 58 toggles `mod_caps`; break 58 has no effect.
- Translation applies to make events only; break events never enqueue.
- Non-extended keys:
  - Keymap gives a {base, shifted} pair.
  - Shift selects shifted.
  - Caps inverts the selection for letters a–z only.
  - Ctrl with a letter gives `letter & 8'h1F`; Ctrl overrides Shift/Caps.
  - Fixed codes: Enter 5A->0D, Backspace 66->08, Esc 76->1B, Tab 0D->09, Space 29->20.
- Extended keys:
  - Up E0 75->80, Down E0 72->81, Left E0 6B->82, Right E0 74->83.
  - Home E0 6C->84, End E0 69->85, Delete E0 71->7F, KP-Enter E0 5A->0D.
  - Other extended codes enqueue nothing.
- Unmapped code (keymap entry 00): nothing enqueued; modifiers unchanged.
- Typematic repeats (repeated makes without a break) each enqueue a character.
- Full FIFO:
  - A translated character is dropped and `overflow` pulses.
  - Exception: if a pop occurs in the same cycle, the write is accepted.
- Empty FIFO: no bypass; a write and a pop cannot coincide because `out_valid`=0.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=00.
  - `mod_shift`=`mod_ctrl`=`mod_caps`=0, `overflow`=0.
  - FSM in IDLE; FIFO pointers 0.
- Latency:
  - Strobe at edge N registers the event and the keymap lookup.
  - The FIFO write occurs at edge N+1.
  - `out_valid` rises after edge N+1 (2 cycles) when the FIFO was empty.
- Modifier and caps outputs update at edge N.
- `overflow` is asserted in the cycle following edge N+1.
- `out_data` is registered, stable while `out_valid`=1 and not popped.
- After a pop, the next entry is presented on the following cycle.
- Back-to-back `ps2_hit` on consecutive cycles must be handled with no byte lost.
- Reset asserted mid-sequence (e.g. after E0): FSM returns to IDLE and the FIFO empties immediately. The next byte is parsed as unprefixed.

## Configuration
- `PS2ASCII_CAPSLOCK_EN` defined:
  - Caps Lock tracking as above.
  - `mod_caps` reflects the toggle.
- Undefined:
  - Code 58 is treated as unmapped.
  - `mod_caps` is tied 0.
  - Letters depend only on Shift/Ctrl.

## Structure
- Shared package `ps2_pkg`:
  - Prefix constants (E0, F0).
  - Modifier scancodes.
  - Control-key and extended output codes (0D, 08, 1B, 09, 7F, 80–85).
  - FSM state enum.
- Sub-module `ps2_keymap`:
  - Combinational ROM, 7-bit scancode -> {base[7:0], shifted[7:0], is_letter}.
  - US layout, scancodes 00–7F.
- FIFO is inline: register array with pointers one bit wider than log2(DEPTH) for full/empty.

## Test plan
- Stream 1C (a), then F0 1C, `out_ready`=1:
  - One entry 61, `out_valid` high 2 cycles after the 1C strobe.
  - The break enqueues nothing.
- 12, 1C, F0 1C, F0 12, then 1C:
  - Entries 41 then 61.
  - `mod_shift` 1 between the 12 and the F0 12 strobes.
- 58, F0 58, 1C, 12, 1C, 16:
  - With the macro: `mod_caps`=1; entries 41, 61, 21 (Shift+1 = '!', caps ignored).
  - Without the macro: `mod_caps`=0; entries 61, 41, 21.
- E0 75, E0 F0 75, 14, 21 (c):
  - Entries 80, 03.
  - The extended break enqueues nothing.
- `out_ready`=0, DEPTH=8, send 9 makes of 1C:
  - 8 entries of 61; one `overflow` pulse on the 9th.
  - With `out_ready`=1 in the same cycle as a full-state write, no overflow.
- Send E0, assert `reset_n`=0 for 1 cycle, release, send 75:
  - Nothing enqueued (75 unmapped non-extended).
  - All outputs at reset values after reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, state enum and keymap entry type for the
// PS/2 set-2 scancode to character pipeline.
package ps2_pkg;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_DEL   = 8'h7F;
  localparam logic [7:0] CH_UP    = 8'h80;
  localparam logic [7:0] CH_DOWN  = 8'h81;
  localparam logic [7:0] CH_LEFT  = 8'h82;
  localparam logic [7:0] CH_RIGHT = 8'h83;
  localparam logic [7:0] CH_HOME  = 8'h84;
  localparam logic [7:0] CH_END   = 8'h85;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] base;
    logic [7:0] shifted;
    logic       is_letter;
  } keymap_t;

  // Keyboard self-test, ack, echo, resend and error bytes
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// US-layout set-2 keymap ROM: 7-bit scancode to base/shifted
// character pair plus a letter flag. Entry 00 means unmapped.
import ps2_pkg::*;

module ps2_keymap (
  input  logic [6:0] code,
  output logic [7:0] base,
  output logic [7:0] shifted,
  output logic       is_letter
);

  keymap_t e;

  function automatic keymap_t lt(input logic [7:0] c);
    return '{c, c - 8'h20, 1'b1};
  endfunction

  function automatic keymap_t ch(input logic [7:0] b,
                                 input logic [7:0] s);
    return '{b, s, 1'b0};
  endfunction

  always_comb begin
    e = '{8'h00, 8'h00, 1'b0};
    case (code)
      7'h15: e = lt("q");
      7'h1A: e = lt("z");
      7'h1B: e = lt("s");
      7'h1C: e = lt("a");
      7'h1D: e = lt("w");
      7'h21: e = lt("c");
      7'h22: e = lt("x");
      7'h23: e = lt("d");
      7'h24: e = lt("e");
      7'h2A: e = lt("v");
      7'h2B: e = lt("f");
      7'h2C: e = lt("t");
      7'h2D: e = lt("r");
      7'h31: e = lt("n");
      7'h32: e = lt("b");
      7'h33: e = lt("h");
      7'h34: e = lt("g");
      7'h35: e = lt("y");
      7'h3A: e = lt("m");
      7'h3B: e = lt("j");
      7'h3C: e = lt("u");
      7'h42: e = lt("k");
      7'h43: e = lt("i");
      7'h44: e = lt("o");
      7'h4B: e = lt("l");
      7'h4D: e = lt("p");
      7'h0E: e = ch(8'h60, 8'h7E);
      7'h16: e = ch("1", "!");
      7'h1E: e = ch("2", "@");
      7'h26: e = ch("3", "#");
      7'h25: e = ch("4", "$");
      7'h2E: e = ch("5", "%");
      7'h36: e = ch("6", "^");
      7'h3D: e = ch("7", "&");
      7'h3E: e = ch("8", "*");
      7'h46: e = ch("9", "(");
      7'h45: e = ch("0", ")");
      7'h4E: e = ch("-", "_");
      7'h55: e = ch("=", "+");
      7'h54: e = ch("[", "{");
      7'h5B: e = ch("]", "}");
      7'h5D: e = ch("\\", "|");
      7'h4C: e = ch(";", ":");
      7'h52: e = ch("'", "\"");
      7'h41: e = ch(",", "<");
      7'h49: e = ch(".", ">");
      7'h4A: e = ch("/", "?");
      7'h29: e = ch(" ", " ");
      7'h5A: e = ch(CH_CR, CH_CR);
      7'h66: e = ch(CH_BS, CH_BS);
      7'h76: e = ch(CH_ESC, CH_ESC);
      7'h0D: e = ch(CH_TAB, CH_TAB);
      default: e = '{8'h00, 8'h00, 1'b0};
    endcase
  end

  assign base      = e.base;
  assign shifted   = e.shifted;
  assign is_letter = e.is_letter;

endmodule

// File: rtl/ps2_ascii_fifo.sv
// Scancode parser, modifier tracker and character FIFO.
// Caps Lock support is enabled by defining PS2ASCII_CAPSLOCK_EN.
import ps2_pkg::*;

module ps2_ascii_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] ps2_data,
  input  logic       ps2_hit,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_caps,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  ps2_state_e state_q, state_d;
  logic shl_q, shl_d, shr_q, shr_d;
  logic ctl_q, ctl_d, ctr_q, ctr_d;
  logic caps_q, caps_d;
  logic ev_wr_q, ev_wr_d;
  logic [7:0] ev_ch_q, ev_ch_d;
  logic ovf_q, ovf_d;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  logic mk, brk, ext, upper;
  logic empty, full, pop, push;
  logic [7:0] km_base, km_shift;
  logic km_letter;

  ps2_keymap u_keymap (
    .code      (ps2_data[6:0]),
    .base      (km_base),
    .shifted   (km_shift),
    .is_letter (km_letter)
  );

  always_comb begin
    state_d = state_q;
    mk  = 1'b0;
    brk = 1'b0;
    ext = 1'b0;
    if (ps2_hit) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ps2_data == PFX_EXT) state_d = ST_EXT;
          else if (ps2_data == PFX_BRK) state_d = ST_BRK;
          else mk = !is_ignored(ps2_data);
        end
        ST_EXT: begin
          ext = 1'b1;
          if (ps2_data == PFX_BRK) state_d = ST_EXTBRK;
          else begin
            mk = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXTBRK: begin
          brk = 1'b1;
          ext = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    shl_d  = shl_q;
    shr_d  = shr_q;
    ctl_d  = ctl_q;
    ctr_d  = ctr_q;
    caps_d = caps_q;
    if (mk || brk) begin
      if (!ext && ps2_data == SC_LSHIFT) shl_d = mk;
      if (!ext && ps2_data == SC_RSHIFT) shr_d = mk;
      if (!ext && ps2_data == SC_CTRL) ctl_d = mk;
      if (ext && ps2_data == SC_CTRL) ctr_d = mk;
    end
`ifdef PS2ASCII_CAPSLOCK_EN
    if (mk && !ext && ps2_data == SC_CAPS) caps_d = !caps_q;
`else
    caps_d = 1'b0;
`endif
  end

  // Translation uses the modifier state from before this byte
  always_comb begin
    upper   = (shl_q | shr_q) ^ (caps_q & km_letter);
    ev_wr_d = 1'b0;
    ev_ch_d = 8'h00;
    if (mk && !ext && !ps2_data[7] && km_base != 8'h00) begin
      ev_wr_d = 1'b1;
      if ((ctl_q | ctr_q) && km_letter) ev_ch_d = km_base & 8'h1F;
      else ev_ch_d = upper ? km_shift : km_base;
    end else if (mk && ext) begin
      ev_wr_d = 1'b1;
      case (ps2_data)
        8'h75: ev_ch_d = CH_UP;
        8'h72: ev_ch_d = CH_DOWN;
        8'h6B: ev_ch_d = CH_LEFT;
        8'h74: ev_ch_d = CH_RIGHT;
        8'h6C: ev_ch_d = CH_HOME;
        8'h69: ev_ch_d = CH_END;
        8'h71: ev_ch_d = CH_DEL;
        8'h5A: ev_ch_d = CH_CR;
        default: ev_wr_d = 1'b0;
      endcase
    end
  end

  // A pop frees the head slot, so a full FIFO still takes the write
  always_comb begin
    empty = (wp_q == rp_q);
    full  = (wp_q[AW] != rp_q[AW]) &&
            (wp_q[AW-1:0] == rp_q[AW-1:0]);
    pop   = !empty && out_ready;
    push  = ev_wr_q && (!full || pop);
    ovf_d = ev_wr_q && full && !pop;
    wp_d  = push ? wp_q + PTR_ONE : wp_q;
    rp_d  = pop ? rp_q + PTR_ONE : rp_q;
    mem_d = mem_q;
    if (push) mem_d[wp_q[AW-1:0]] = ev_ch_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shl_q   <= 1'b0;
      shr_q   <= 1'b0;
      ctl_q   <= 1'b0;
      ctr_q   <= 1'b0;
      caps_q  <= 1'b0;
      ev_wr_q <= 1'b0;
      ev_ch_q <= 8'h00;
      ovf_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      mem_q   <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      shl_q   <= shl_d;
      shr_q   <= shr_d;
      ctl_q   <= ctl_d;
      ctr_q   <= ctr_d;
      caps_q  <= caps_d;
      ev_wr_q <= ev_wr_d;
      ev_ch_q <= ev_ch_d;
      ovf_q   <= ovf_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      mem_q   <= mem_d;
    end
  end

  assign out_valid = !empty;
  assign out_data  = mem_q[rp_q[AW-1:0]];
  assign overflow  = ovf_q;
  assign mod_shift = shl_q | shr_q;
  assign mod_ctrl  = ctl_q | ctr_q;
  assign mod_caps  = caps_q;

endmodule
